// File: rtl/hwag_spi_pkg.sv
// hwag_spi_pkg: command codes, status encoding and FSM states shared by the SPI command controller
package hwag_spi_pkg;
    localparam logic [7:0] CMD_WR  = 8'hA5;
    localparam logic [7:0] CMD_RD  = 8'h5A;
    localparam logic [7:0] CMD_NOP = 8'h00;
    localparam int ST_OK     = 0;
    localparam int ST_CRC    = 1;
    localparam int ST_BADCMD = 2;
    localparam int ST_TMO    = 3;
    localparam int ST_OVR    = 4;
    localparam logic [7:0] STATUS_OK     = 8'(1 << ST_OK);
    localparam logic [7:0] STATUS_CRC    = 8'(1 << ST_CRC);
    localparam logic [7:0] STATUS_BADCMD = 8'(1 << ST_BADCMD);
    localparam logic [7:0] STATUS_TMO    = 8'(1 << ST_TMO);
    localparam logic [7:0] STATUS_OVR    = 8'(1 << ST_OVR);
    typedef enum logic [1:0] {IDLE, DECODE, REQ} state_t;
endpackage

// File: rtl/hwag_spi_cmd_ctrl_sat_counter8.sv
// sat_counter8: 8-bit event counter that sticks at 255
module sat_counter8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    output logic [7:0] count
);
    // count up on inc until all ones
    always_ff @(posedge clk or negedge rst)
        if (!rst) count <= '0;
        else if (inc && count != 8'hFF) count <= count + 8'd1;
endmodule

// File: rtl/hwag_spi_cmd_ctrl.sv
// hwag_spi_cmd_ctrl: turns received SPI frames into single HWAG bus transactions and reports status
module hwag_spi_cmd_ctrl
    import hwag_spi_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_ss_rise,
    input  logic        spi_crc_rx_equal,
    input  logic [7:0]  spi_hwag_cmd,
    input  logic [7:0]  spi_hwag_addr,
    input  logic [31:0] spi_hwag_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [7:0]  bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] resp_data,
    output logic [7:0]  resp_status,
    output logic [7:0]  crc_err_cnt,
    output logic [7:0]  timeout_cnt,
    output logic        busy
);
    state_t      state;
    logic [7:0]  cmd, addr, tmo;
    logic [31:0] data;
    logic        crc_ok, ovr, ovr_now, ack_hit, tmo_hit, crc_fail, done;
    logic [7:0]  status_base;

    assign busy     = state != IDLE;
    assign bus_req  = state == REQ;
    assign ovr_now  = ovr | (spi_ss_rise & busy);
    assign ack_hit  = bus_req && bus_ack;
    assign tmo_hit  = bus_req && !bus_ack && tmo == 8'(TIMEOUT_CYC - 1);
    assign crc_fail = state == DECODE && !crc_ok;
    assign done     = (state == DECODE && !(crc_ok && (cmd == CMD_WR || cmd == CMD_RD))) || ack_hit || tmo_hit;

    // status of the frame finishing this cycle (only meaningful when done)
    always_comb
        status_base = state == DECODE ? (!crc_ok ? STATUS_CRC : cmd == CMD_NOP ? STATUS_OK : STATUS_BADCMD)
                    : tmo_hit ? STATUS_TMO : STATUS_OK;

    // frame capture, decode and bus transaction sequencing
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state     <= IDLE;
            cmd       <= '0;
            addr      <= '0;
            data      <= '0;
            crc_ok    <= 1'b0;
            tmo       <= '0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            resp_data <= '0;
        end else begin
            case (state)
                IDLE: if (spi_ss_rise) begin
                    cmd    <= spi_hwag_cmd;
                    addr   <= spi_hwag_addr;
                    data   <= spi_hwag_data;
                    crc_ok <= spi_crc_rx_equal;
                    state  <= DECODE;
                end
                DECODE: if (!crc_ok) state <= IDLE;
                else if (cmd == CMD_WR) begin
                    bus_we    <= 1'b1;
                    bus_addr  <= addr;
                    bus_wdata <= data;
                    state     <= REQ;
                end else if (cmd == CMD_RD) begin
                    bus_we   <= 1'b0;
                    bus_addr <= addr;
                    state    <= REQ;
                end else state <= IDLE;
                REQ: if (bus_ack) begin
                    if (!bus_we) resp_data <= bus_rdata;
                    tmo   <= '0;
                    state <= IDLE;
                end else if (tmo_hit) begin
                    tmo   <= '0;
                    state <= IDLE;
                end else tmo <= tmo + 8'd1;
                default: state <= IDLE;
            endcase
        end

    // status is written once per accepted frame; a frame arriving while busy marks overrun on it
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            resp_status <= '0;
            ovr         <= 1'b0;
        end else if (done) begin
            resp_status <= status_base | (STATUS_OVR & {8{ovr_now}});
            ovr         <= 1'b0;
        end else ovr <= ovr_now;

    sat_counter8 u_crc_cnt (.clk(clk), .rst(rst), .inc(crc_fail), .count(crc_err_cnt));
    sat_counter8 u_tmo_cnt (.clk(clk), .rst(rst), .inc(tmo_hit), .count(timeout_cnt));
endmodule

// File: tb/tb_hwag_spi_cmd_ctrl.sv
// tb_hwag_spi_cmd_ctrl: directed frames with hand-computed bus and status expectations
module tb_hwag_spi_cmd_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        spi_ss_rise = 1'b0;
    logic        spi_crc_rx_equal = 1'b0;
    logic [7:0]  spi_hwag_cmd = '0;
    logic [7:0]  spi_hwag_addr = '0;
    logic [31:0] spi_hwag_data = '0;
    logic        bus_req, bus_we, busy;
    logic [7:0]  bus_addr, resp_status, crc_err_cnt, timeout_cnt;
    logic [31:0] bus_wdata, resp_data;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    int          n_tests = 0;
    int          n_fail = 0;

    hwag_spi_cmd_ctrl #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .spi_ss_rise(spi_ss_rise), .spi_crc_rx_equal(spi_crc_rx_equal),
        .spi_hwag_cmd(spi_hwag_cmd), .spi_hwag_addr(spi_hwag_addr), .spi_hwag_data(spi_hwag_data),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .resp_data(resp_data), .resp_status(resp_status),
        .crc_err_cnt(crc_err_cnt), .timeout_cnt(timeout_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] a, input logic [31:0] d, input logic ok);
        spi_ss_rise      = 1'b1;
        spi_hwag_cmd     = c;
        spi_hwag_addr    = a;
        spi_hwag_data    = d;
        spi_crc_rx_equal = ok;
        tick();
        spi_ss_rise = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        logic seen;
        repeat (3) tick();
        check("rst_req", bus_req, 0);
        check("rst_busy", busy, 0);
        check("rst_bus", {bus_we, bus_addr}, 0);
        check("rst_wdata", bus_wdata, 0);
        check("rst_resp", resp_data, 0);
        check("rst_status_cnts", {resp_status, crc_err_cnt, timeout_cnt}, 0);
        rst = 1'b1;
        tick();
        // write with ack on the third REQ cycle
        frame(8'hA5, 8'h10, 32'hDEADBEEF, 1'b1);
        check("wr_req_lat1", bus_req, 0);
        check("wr_busy", busy, 1);
        tick();
        check("wr_req_lat2", bus_req, 1);
        check("wr_we", bus_we, 1);
        check("wr_addr", bus_addr, 32'h10);
        check("wr_wdata", bus_wdata, 32'hDEADBEEF);
        tick();
        tick();
        check("wr_req_hold", {bus_req, bus_we, bus_addr}, {23'd0, 1'b1, 1'b1, 8'h10});
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        check("wr_done", {bus_req, busy}, 0);
        check("wr_status", resp_status, 32'h01);
        check("wr_resp_unch", resp_data, 0);
        // read
        frame(8'h5A, 8'h22, 32'h0, 1'b1);
        tick();
        check("rd_req", {bus_req, bus_we, bus_addr}, {23'd0, 1'b1, 1'b0, 8'h22});
        bus_rdata = 32'h12345678;
        bus_ack   = 1'b1;
        check("rd_busy_at_ack", busy, 1);
        tick();
        bus_ack   = 1'b0;
        bus_rdata = 32'hFFFFFFFF;
        check("rd_busy_low", {bus_req, busy}, 0);
        check("rd_data", resp_data, 32'h12345678);
        check("rd_status", resp_status, 32'h01);
        // ack outside REQ is ignored
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        check("idle_ack_ign", {busy, resp_data}, {1'b0, 32'h12345678});
        // CRC failures saturate the error counter
        seen = 1'b0;
        for (int i = 0; i < 257; i++) begin
            frame(8'hA5, 8'h30, 32'h1, 1'b0);
            seen |= bus_req;
            tick();
            seen |= bus_req;
            if (i == 0) check("crc_cnt_first", crc_err_cnt, 1);
            if (i == 254) check("crc_cnt_255", crc_err_cnt, 255);
        end
        check("crc_no_req", seen, 0);
        check("crc_status", resp_status, 32'h02);
        check("crc_cnt_sat", crc_err_cnt, 255);
        check("crc_resp_unch", resp_data, 32'h12345678);
        // read timeout
        frame(8'h5A, 8'h33, 32'h0, 1'b1);
        tick();
        hi = 0;
        for (int i = 0; i < 40 && bus_req; i++) begin
            hi++;
            tick();
        end
        check("tmo_req_cycles", hi, 16);
        check("tmo_status", resp_status, 32'h08);
        check("tmo_cnt", timeout_cnt, 1);
        check("tmo_idle", busy, 0);
        // ack on the timeout cycle wins
        frame(8'h5A, 8'h44, 32'h0, 1'b1);
        tick();
        repeat (15) tick();
        check("tmo_edge_req", bus_req, 1);
        bus_rdata = 32'hCAFEF00D;
        bus_ack   = 1'b1;
        tick();
        bus_ack = 1'b0;
        check("tmo_edge_status", resp_status, 32'h01);
        check("tmo_edge_cnt", timeout_cnt, 1);
        check("tmo_edge_data", resp_data, 32'hCAFEF00D);
        // overrun: second frame while in REQ
        frame(8'hA5, 8'h55, 32'h11112222, 1'b1);
        tick();
        frame(8'hA5, 8'h66, 32'h33334444, 1'b1);
        check("ovr_inflight", {bus_req, bus_addr, bus_wdata}, {1'b1, 8'h55, 32'h11112222});
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        check("ovr_status", resp_status, 32'h11);
        seen = 1'b0;
        repeat (4) begin
            seen |= bus_req | busy;
            tick();
        end
        check("ovr_dropped", seen, 0);
        frame(8'h00, 8'h00, 32'h0, 1'b1);
        tick();
        check("nop_status", resp_status, 32'h01);
        frame(8'h3C, 8'h00, 32'h0, 1'b1);
        tick();
        check("badcmd_status", {bus_req, busy, resp_status}, 32'h04);
        // asynchronous reset during REQ
        frame(8'hA5, 8'h77, 32'hAAAA5555, 1'b1);
        tick();
        check("rstm_req", bus_req, 1);
        #2 rst = 1'b0;
        #1;
        check("rstm_req_drop", {bus_req, busy, bus_we}, 0);
        check("rstm_bus", {bus_addr, bus_wdata[23:0]}, 0);
        check("rstm_resp", resp_data, 0);
        check("rstm_cnts", {resp_status, crc_err_cnt, timeout_cnt}, 0);
        tick();
        rst = 1'b1;
        tick();
        frame(8'h5A, 8'h88, 32'h0, 1'b1);
        tick();
        check("post_rst_req", {bus_req, bus_we, bus_addr}, {23'd0, 1'b1, 1'b0, 8'h88});
        bus_rdata = 32'h0BADF00D;
        bus_ack   = 1'b1;
        tick();
        bus_ack = 1'b0;
        check("post_rst_data", resp_data, 32'h0BADF00D);
        check("post_rst_status", {busy, resp_status}, 32'h01);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hwag_spi_cmd_ctrl.md
Name: hwag_spi_cmd_ctrl

Overview:
Command sequencer between the SPI RX frame decoder and the HWAG register bus.
- At each frame end (SS rising edge) it checks the CRC result and decodes CMD.
- It issues one register write or read transaction on the HWAG bus and waits for an acknowledge, with a timeout.
- It latches the read data and a status byte for the next SPI TX frame, and keeps saturating error counters.

Parameters:
- TIMEOUT_CYC, 16: cycles to wait for bus_ack before aborting; legal range 2..255.
- CMD_WR, 8'hA5: command code for a register write.
- CMD_RD, 8'h5A: command code for a register read.
- CMD_NOP, 8'h00: no-op; only refreshes the status byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- spi_ss_rise  in  1  one-cycle pulse at frame end.
- spi_crc_rx_equal  in  1  received CRC matches the computed CRC; valid when spi_ss_rise is high.
- spi_hwag_cmd  in  8  frame command byte.
- spi_hwag_addr  in  8  frame register address.
- spi_hwag_data  in  32  frame write data.
- bus_req  out  1  transaction request; held until ack or timeout.
- bus_we  out  1  1 = write, 0 = read; stable while bus_req is high.
- bus_addr  out  8  register address; stable while bus_req is high.
- bus_wdata  out  32  write data; stable while bus_req is high.
- bus_ack  in  1  one-cycle acknowledge; bus_rdata is valid in the same cycle.
- bus_rdata  in  32  read data.
- resp_data  out  32  last read data, presented to the TX framer.
- resp_status  out  8  status of the last frame.
- crc_err_cnt  out  8  count of CRC failures; saturates at 255.
- timeout_cnt  out  8  count of bus timeouts; saturates at 255.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0.
- resp_status bit meanings: [0] ok, [1] crc_err, [2] bad_cmd, [3] timeout, [4] overrun, [7:5] always 0.
- Frame capture: on spi_ss_rise in IDLE, register cmd, addr, data and crc_equal. Go to DECODE on the next cycle.
- DECODE state, in priority order:
  - crc_equal = 0: status = 8'h02, crc_err_cnt +1 (saturating), go to IDLE.
  - cmd = CMD_WR: bus_we = 1, drive addr and wdata, go to REQ.
  - cmd = CMD_RD: bus_we = 0, drive addr, go to REQ.
  - cmd = CMD_NOP: status = 8'h01, go to IDLE.
  - any other cmd: status = 8'h04, go to IDLE.
- REQ state:
  - bus_req = 1; the timeout counter increments every cycle.
  - bus_ack = 1: drop bus_req in the next cycle. For a read, resp_data <= bus_rdata. Status = 8'h01. Go to IDLE.
  - Counter reaches TIMEOUT_CYC - 1 with no ack: drop bus_req, status = 8'h08, timeout_cnt +1 (saturating), go to IDLE.
  - bus_ack in the same cycle as the timeout edge: the ack wins.
- Latency: spi_ss_rise to bus_req high is exactly 2 cycles. bus_ack to busy low is 1 cycle.
- Overrun:
  - spi_ss_rise while busy: the frame is dropped and the transaction in flight is unaffected.
  - A sticky overrun flag is set and OR'd into bit 4 of the final status of the current transaction.
  - The flag clears when that status is written.
- resp_data changes only on a successful read; writes, errors and NOP leave it unchanged.
- Status is written exactly once per accepted frame, at the last cycle of the frame's handling.
- rst asserted mid-transaction: bus_req drops immediately and asynchronously; all state returns to reset values.
- bus_ack seen outside REQ is ignored.

Decomposition:
- Package hwag_spi_pkg holds:
  - the CMD_* codes;
  - the status bit index constants and the STATUS_OK, STATUS_CRC, STATUS_BADCMD, STATUS_TMO, STATUS_OVR values;
  - the state enum (IDLE, DECODE, REQ).
- One sub-module, sat_counter8: 8-bit saturating counter with asynchronous active-low reset and an increment enable. It is instantiated twice, once for crc_err_cnt and once for timeout_cnt.

Test Plan:
- Write: cmd=A5, addr=0x10, data=0xDEADBEEF, crc ok, ack after 3 cycles.
  Required: bus_req high 2 cycles after ss_rise with we=1, addr=0x10, wdata=DEADBEEF; status=0x01; resp_data unchanged (0).
- Read: cmd=5A, addr=0x22, bus_rdata=0x12345678 with ack.
  Required: resp_data=0x12345678, status=0x01, busy low 1 cycle after ack.
- CRC failure: crc_equal=0, repeated 257 times.
  Required: no bus_req; status=0x02; crc_err_cnt saturates at 255.
- Timeout: read frame with no ack.
  Required: bus_req high for exactly TIMEOUT_CYC cycles; status=0x08; timeout_cnt=1. A second case with ack on the timeout cycle gives status=0x01.
- Overrun: second ss_rise while in REQ, then ack.
  Required: status=0x11; the second frame produces no bus_req.
- Reset mid-REQ: assert rst low while bus_req is high.
  Required: bus_req and all outputs 0 asynchronously; the next valid frame completes normally.
